// File: rtl/shift_pkg.sv
// Shared definitions for the 8-bit shift sequencer and its shifter stage.
//   - op encodings (SH_*), FSM state type, datapath constants
//   - mux4: the 4-input mux primitive every shifter bit is built from
package shift_pkg;

  localparam int DATA_W   = 8;
  localparam int SHAMT_W  = 3;
  localparam int STEP_MAX = 3;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;

  function automatic logic mux4(input logic [1:0] sel,
                                input logic a0, input logic a1,
                                input logic a2, input logic a3);
    logic y;
    case (sel)
      2'b00:   y = a0;
      2'b01:   y = a1;
      2'b10:   y = a2;
      default: y = a3;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/shifter8_stage.sv
// Combinational single-pass shifter: shifts d_in by k (0..3) using op.
// Ports:
//   d_in  [7:0]  operand
//   k     [1:0]  shift amount for this pass
//   op    [1:0]  SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   d_out [7:0]  shifted result
// Each output bit is a 4-input mux over k; each mux leg is itself a
// 4-input mux over op, selecting the source bit for that distance.
module shifter8_stage
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] d_in,
  input  logic [1:0]        k,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] d_out
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    logic [3:0] taps;

    for (genvar j = 0; j < 4; j++) begin : g_tap
      logic lsl_b;
      logic lsr_b;
      logic asr_b;
      logic ror_b;

      if (i >= j) begin : g_lsl_src
        assign lsl_b = d_in[i-j];
      end else begin : g_lsl_fill
        assign lsl_b = 1'b0;
      end

      if (i + j <= DATA_W - 1) begin : g_rsh_src
        assign lsr_b = d_in[i+j];
        assign asr_b = d_in[i+j];
      end else begin : g_rsh_fill
        assign lsr_b = 1'b0;
        assign asr_b = d_in[DATA_W-1];
      end

      // Bit 0 wraps around to bit 7, i.e. rotate right.
      assign ror_b = d_in[(i+j) % DATA_W];

      // Leg order follows the op encoding: LSL, LSR, ASR, ROR.
      assign taps[j] = mux4(op, lsl_b, lsr_b, asr_b, ror_b);
    end

    assign d_out[i] = mux4(k, taps[0], taps[1], taps[2], taps[3]);
  end

endmodule

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shift sequencer driving shifter8_stage.
// A request (data, 0..7 amount, op) is iterated through the stage in
// passes of up to 3 until the full amount is applied; the result is then
// presented on a valid/ready output.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   in_valid/in_ready             request handshake
//   in_data, in_shamt, in_op      operand, total shift, operation
//   out_valid/out_ready           result handshake
//   out_data, out_zero            result and its zero flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// SHIFT | one stage pass per cycle until rem reaches 0
// DONE  | first cycle loads output regs, then holds until out_ready
module shift_seq8
  import shift_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [SHAMT_W-1:0]  in_shamt,
  input  logic [1:0]          in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_zero
);

  seq_state_t          state_q, state_d;
  logic [DATA_W-1:0]   work_q;
  logic [SHAMT_W-1:0]  rem_q;
  logic [1:0]          op_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_zero_q;

  logic [1:0]          step;
  logic [SHAMT_W-1:0]  rem_next;
  logic [DATA_W-1:0]   stage_out;
  logic                load_req;
  logic                do_shift;
  logic                load_out;
  logic                clear_out;

  assign step     = (rem_q > SHAMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];
  assign rem_next = rem_q - {1'b0, step};

  shifter8_stage u_stage (
    .d_in  (work_q),
    .k     (step),
    .op    (op_q),
    .d_out (stage_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_req  = 1'b0;
    do_shift  = 1'b0;
    load_out  = 1'b0;
    clear_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_req = 1'b1;
          state_d  = (in_shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (rem_next == '0) state_d = DONE;
      end
      DONE: begin
        // Output regs are loaded on the first DONE edge; handoff can only
        // happen once out_valid is actually visible.
        if (!out_valid_q) begin
          load_out = 1'b1;
        end else if (out_ready) begin
          clear_out = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q <= '0;
      rem_q  <= '0;
      op_q   <= SH_LSL;
    end else if (load_req) begin
      work_q <= in_data;
      rem_q  <= in_shamt;
      op_q   <= in_op;
    end else if (do_shift) begin
      work_q <= stage_out;
      rem_q  <= rem_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_data_q  <= work_q;
      out_zero_q  <= (work_q == '0);
    end else if (clear_out) begin
      out_valid_q <= 1'b0;
    end
  end

  // Gated with reset_n so the block never advertises ready while held in reset.
  assign in_ready  = (state_q == IDLE) && reset_n;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_shift_seq8.sv
module tb_shift_seq8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;

  always #5 clk = ~clk;

  shift_seq8 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [7:0] data;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   txn_id = 0;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s,
                                           input logic [1:0] o);
    logic [15:0] dd;
    logic [7:0]  r;
    case (o)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = 8'($signed(d) >>> s);
      default: begin
        dd = {d, d} >> s;
        r  = dd[7:0];
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (txn %0d): observed %0h expected %0h", tag, txn_id, obs, exp);
    end
  endtask

  // One complete request/response. hold = cycles out_ready stays low once
  // out_valid is seen; junk = keep driving a different request while busy.
  task automatic txn(input logic [7:0] d, input logic [2:0] s, input logic [1:0] o,
                     input int hold, input bit junk);
    exp_t e;
    exp_t got;
    int   lat;
    int   guard;
    txn_id++;
    @(negedge clk);
    out_ready = (hold == 0);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = o;
    @(posedge clk);
    e.data = ref_shift(d, s, o);
    e.zero = (e.data == 8'h00);
    e.lat  = 1 + (int'(s) + 2) / 3;
    sb.push_back(e);
    @(negedge clk);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = ~d;
      in_shamt = 3'd0;
      in_op    = o ^ 2'b11;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 10);
    in_valid = 1'b0;
    check("out_valid_arrives", out_valid, 1);
    check("scoreboard_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("out_data", out_data, got.data);
      check("out_zero", out_zero, got.zero);
      check("latency", lat, got.lat);
      if (hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          @(posedge clk);
          @(negedge clk);
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, got.data);
          check("hold_zero", out_zero, got.zero);
          check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("valid_drops", out_valid, 0);
    check("back_to_idle", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_shamt  = 3'd0;
    in_op     = 2'b00;
    out_ready = 1'b1;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_valid", out_valid, 0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed cases
    txn(8'h81, 3'd7, 2'b00, 0, 1'b0);   // LSL -> 80, 4 edges
    txn(8'h80, 3'd5, 2'b01, 0, 1'b0);   // LSR -> 04, 3 edges
    txn(8'h80, 3'd7, 2'b10, 0, 1'b0);   // ASR -> FF, 4 edges
    txn(8'h40, 3'd2, 2'b10, 0, 1'b0);   // ASR -> 10
    txn(8'h81, 3'd3, 2'b11, 0, 1'b0);   // ROR -> 30, 2 edges
    txn(8'hA5, 3'd0, 2'b11, 0, 1'b0);   // ROR by 0 -> A5, 1 edge
    txn(8'h01, 3'd0, 2'b00, 0, 1'b0);   // LSL by 0 -> 01, 1 edge
    txn(8'h0F, 3'd4, 2'b01, 5, 1'b0);   // zero result, 5 cycles back-pressure
    txn(8'h81, 3'd7, 2'b00, 0, 1'b1);   // new request while busy is ignored

    // Reset abort in the middle of SHIFT (previous result 80 is non-zero)
    txn_id++;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h81;
    in_shamt  = 3'd7;
    in_op     = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", in_ready, 0);
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 8'h00);
    check("abort_in_ready", in_ready, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_spurious_valid", out_valid, 0);
    end
    txn(8'h3C, 3'd6, 2'b11, 0, 1'b0);   // normal operation after abort

    // Every op and amount, random data
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 8; s++) begin
        txn(8'($urandom), 3'(s), 2'(o), 0, 1'b0);
      end
    end

    // Random traffic with random consumer back-pressure
    for (int n = 0; n < 500; n++) begin
      txn(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq8.md
Name: shift_seq8

Overview:
- Multi-cycle 8-bit shift sequencer that sits directly upstream of, and drives, the combinational 4-to-1-mux shifter stage (shift amount 0..3 per pass).
- Accepts a shift request (data, 3-bit amount, op) over a valid/ready handshake.
- Iterates the stage in steps of up to 3 until the full amount (0..7) is applied, then presents the result with a valid/ready handshake.
- Supports LSL, LSR, ASR and ROR.

Parameters:
- None. The datapath is fixed at 8 bits, the amount at 3 bits, and the per-pass step limit at 3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; equals (state==IDLE).
- in_data  in  8  operand.
- in_shamt  in  3  total shift amount, 0..7.
- in_op  in  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  8  shifted result.
- out_zero  out  1  out_data==8'h00; qualified by out_valid.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, out_valid=0, out_data=8'h00, out_zero=0, internal remaining-count=0, op register=00.
  - in_ready=1 only after reset_n is released.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data into the work register, in_shamt into rem, in_op into the op register.
  - Next state is SHIFT if in_shamt!=0, otherwise DONE (data passes unchanged).
- SHIFT, each cycle:
  - step=min(rem,3).
  - work <= stage(work, step, op).
  - rem <= rem-step.
  - If rem-step==0, go to DONE; otherwise stay in SHIFT.
- DONE:
  - out_valid=1, out_data=work, out_zero=(work==0).
  - Hold all three stable while out_ready=0.
  - On out_ready=1: out_valid drops on the next edge and state returns to IDLE.
  - No new request is accepted in the same cycle as result handoff, so in_ready is 0 in DONE.
- Latency: a request accepted at edge t gives out_valid high after edge t+1+ceil(shamt/3).
  - shamt=0 gives t+1; shamt 1..3 gives t+2; 4..6 gives t+3; 7 gives t+4.
  - Step sequence for 7 is 3,3,1. For 5 it is 3,2.
- Stage semantics for one pass of k=0..3:
  - LSL: zero-fill from bit 0.
  - LSR: zero-fill from bit 7.
  - ASR: fill with work[7].
  - ROR: bits rotate from bit 0 to bit 7. Composing passes gives the exact rotation (ROR by 7 = ROL by 1).
- in_data, in_shamt and in_op are ignored whenever in_ready=0.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately to the reset values. The pending result is lost.
- out_valid never asserts without a preceding accepted request.

Decomposition:
- Shared package (shift_pkg) holds:
  - op encodings SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11;
  - state encodings IDLE/SHIFT/DONE;
  - constants STEP_MAX=3, DATA_W=8, SHAMT_W=3.
- One sub-module: shifter8_stage. It is combinational, has inputs d_in[7:0], k[1:0], op[1:0] and output d_out[7:0], and is built from four-input muxes per bit in the team's existing mux style.
- The sequencer holds only the FSM, the rem counter and the registers.

Test Plan:
- LSL, in_data=8'h81, shamt=7, out_ready=1 -> out_data=8'h80, out_zero=0, out_valid exactly 4 edges after accept, high for 1 cycle.
- LSR 8'h80 by 5 -> 8'h04 after 3 edges. ASR 8'h80 by 7 -> 8'hFF after 4 edges. ASR 8'h40 by 2 -> 8'h10.
- ROR 8'h81 by 3 -> 8'h30 after 2 edges. ROR 8'hA5 by 0 -> 8'hA5 after 1 edge. LSL 8'h01 by 0 -> 8'h01 after 1 edge.
- Zero flag and back-pressure: LSR 8'h0F by 4 -> 8'h00 with out_zero=1. Hold out_ready=0 for 5 cycles -> out_valid, out_data and out_zero stay stable and in_ready stays 0. Raise out_ready -> idle next cycle and in_ready=1.
- Ignored input and reset abort: drive in_valid=1 with new data while in SHIFT -> the request is not captured. Then assert reset_n=0 mid-SHIFT (shamt=7) -> out_valid=0 and out_data=0 asynchronously, and after release the next request completes normally.
- Back-to-back requests: for all ops and all shamt values 0..7, plus random data (500 requests with random out_ready), every result matches a reference model and latency matches 1+ceil(shamt/3).
